dma_stream_writer: RTL and testbench
====================================

Name: dma_stream_writer

Overview:
- Write-side DMA engine. It consumes the accelerator's 128-bit result stream (M_Data/M_Valid/M_Ready) after a DMA_Write_Start pulse.
- Beats are buffered in an internal FIFO, then written to a word-addressed memory port at consecutive addresses starting from a base.
- On completion it raises a done handshake that the host side acknowledges, mirroring the State_RE/Control_RE interrupt scheme.
- Used in place of the bench's file dump, and as the functional model for the write DMA.

Parameters:
DATA_W, 128, stream and memory data width
ADDR_W, 32, memory word-address width
LEN_W, 24, beat-count width
FIFO_DEPTH, 16, internal buffer depth in beats (power of 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
DMA_Write_Start  in  1  one-cycle start pulse
Write_Base  in  ADDR_W  first word address, sampled on start
Write_Len  in  LEN_W  beats to transfer, sampled on start
M_Data  in  DATA_W  stream data from accelerator
M_Valid  in  1  stream valid
M_Ready  out  1  stream ready
Mem_Addr  out  ADDR_W  memory write address
Mem_Data  out  DATA_W  memory write data
Mem_Wr  out  1  write request, held until accepted
Mem_Ack  in  1  memory accepts current write this cycle
Done_Irq  out  1  level, set at completion, held until acknowledged
Done_Ack  in  1  host acknowledge
Busy  out  1  transfer in progress
Err_Start  out  1  sticky: start seen while not IDLE

Behaviour:
- Reset: M_Ready=0, Mem_Wr=0, Mem_Addr=0, Mem_Data=0, Done_Irq=0, Busy=0, Err_Start=0. FIFO empty, counters cleared, state IDLE. A reset in mid-transfer aborts immediately; buffered beats are discarded.
- FSM states:
  - IDLE: on DMA_Write_Start, latch Write_Base and Write_Len and clear in_cnt/out_cnt.
    - Len=0: go to DONE.
    - Otherwise: go to RUN.
  - RUN: accept and drain concurrently. Go to DONE when out_cnt reaches len on the cycle of the final Mem_Ack.
  - DONE: Done_Irq=1. Stay until Done_Ack=1, then go to IDLE with Done_Irq=0 on the next cycle.
- Busy=1 in RUN and DONE.
- Start pulse outside IDLE: ignored, Err_Start set (cleared only by rst).
- Input side:
  - M_Ready = (state==RUN) && !fifo_full && (in_cnt < len), registered-free (combinational from state and flags).
  - A beat is transferred when M_Valid && M_Ready; then push to the FIFO and increment in_cnt.
  - Extra beats after len are never accepted; M_Ready stays 0.
- Output side:
  - When the FIFO is non-empty and no write is pending, load the FIFO head into Mem_Data, set Mem_Wr=1, and Mem_Addr = base + out_cnt.
  - Hold Mem_Addr, Mem_Data and Mem_Wr stable until Mem_Ack.
  - On ack: increment out_cnt, pop the next beat if available, and reissue in the next cycle. This gives back-to-back writes, 1 beat/cycle sustained.
- Latency: first stream beat accepted in cycle N gives Mem_Wr=1 in cycle N+1, assuming Mem_Ack is already high.
- FIFO full/empty:
  - Push and pop in the same cycle are allowed at any occupancy, including full (M_Ready may rise only after the pop is registered; no combinational ready-through).
  - Occupancy never exceeds FIFO_DEPTH.
- Address arithmetic: ADDR_W wraps modulo 2^ADDR_W, with no error.
- Counters are LEN_W wide; max transfer is 2^LEN_W-1 beats.
- Done_Ack while not in DONE: ignored.
- Start and Done_Ack in the same cycle while in DONE: Ack is honoured, Start is flagged as an error.

Decomposition:
- Shared package `tjpu_dma_pkg`:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - DATA_W/ADDR_W defaults.
- Sub-module `sync_fifo`:
  - Parameters DATA_W and DEPTH.
  - Ports: clk, rst, push, din, pop, dout, full, empty.
  - Registered read data valid on the cycle after pop.
  - Reusable for the read-side DMA.

Test Plan:
1. Base=0x100, Len=4, M_Valid constant, Mem_Ack=1 -> writes to 0x100..0x103 with data matching input order; Done_Irq rises 1 cycle after the last ack; Done_Ack returns Busy=0.
2. Len=40, Mem_Ack held 0 for 30 cycles -> exactly 16 beats accepted then M_Ready=0; after ack is released all 40 are written in order, with no loss or duplication.
3. Len=0 start -> DONE next cycle, no Mem_Wr, M_Ready never 1.
4. Start pulse during RUN (Len=8) -> ignored, Err_Start=1; the transfer completes with exactly 8 writes.
5. Base=0xFFFFFFFE, Len=4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
6. rst asserted after 5 of 10 beats -> next cycle all outputs are at reset values; a new start with Len=3 transfers cleanly from an empty FIFO.

Source files
------------

// File: rtl/tjpu_dma_pkg.sv
// Shared definitions for the TJPU DMA engines: FSM state encoding and default widths.
package tjpu_dma_pkg;

  localparam int DMA_DATA_W     = 128;
  localparam int DMA_ADDR_W     = 32;
  localparam int DMA_LEN_W      = 24;
  localparam int DMA_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data: dout holds the popped word from the cycle after pop.
module sync_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [DATA_W-1:0] dout_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign dout      = dout_r;

  // Pointers and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      dout_r   <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        dout_r   <= mem_r[rd_ptr_r[AW-1:0]];
      end
    end
  end

  // Storage array; contents are qualified by the pointers so it needs no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dma_stream_writer.sv
// Write-side DMA: buffers the accelerator result stream and writes it to consecutive memory words,
// then raises a level done interrupt that the host acknowledges.
module dma_stream_writer
  import tjpu_dma_pkg::*;
#(
  parameter int DATA_W     = DMA_DATA_W,
  parameter int ADDR_W     = DMA_ADDR_W,
  parameter int LEN_W      = DMA_LEN_W,
  parameter int FIFO_DEPTH = DMA_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DMA_Write_Start,
  input  logic [ADDR_W-1:0] Write_Base,
  input  logic [LEN_W-1:0]  Write_Len,
  input  logic [DATA_W-1:0] M_Data,
  input  logic              M_Valid,
  output logic              M_Ready,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Mem_Wr,
  input  logic              Mem_Ack,
  output logic              Done_Irq,
  input  logic              Done_Ack,
  output logic              Busy,
  output logic              Err_Start
);
  localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  DEPTH_L  = LEN_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  dma_state_e        state_r;
  dma_state_e        state_nx_s;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  in_cnt_r;
  logic [LEN_W-1:0]  out_cnt_r;
  logic [LEN_W-1:0]  occ_s;
  logic [ADDR_W-1:0] next_addr_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_data_r;
  logic [DATA_W-1:0] fifo_dout_s;
  logic              mem_wr_r;
  logic              pf_valid_r;
  logic              done_irq_r;
  logic              busy_r;
  logic              err_start_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              m_ready_s;
  logic              accept_s;
  logic              ack_s;
  logic              out_free_s;
  logic              load_pf_s;
  logic              load_in_s;
  logic              load_s;
  logic              start_ok_s;

  // Occupancy counts every accepted-but-unacked beat (FIFO, prefetch and write stage),
  // so the whole engine never holds more than FIFO_DEPTH beats.
  assign occ_s      = in_cnt_r - out_cnt_r;
  assign m_ready_s  = (state_r == RUN) && !fifo_full_s && (occ_s < DEPTH_L) && (in_cnt_r < len_r);
  assign accept_s   = M_Valid && m_ready_s;
  assign ack_s      = mem_wr_r && Mem_Ack;
  assign out_free_s = !mem_wr_r || Mem_Ack;
  assign start_ok_s = DMA_Write_Start && (state_r == IDLE);

  // Oldest beat first: prefetched FIFO head, else a fresh beat bypasses an empty FIFO.
  assign load_pf_s  = out_free_s && pf_valid_r;
  assign load_in_s  = out_free_s && !pf_valid_r && fifo_empty_s && accept_s;
  assign load_s     = load_pf_s || load_in_s;
  assign push_s     = accept_s && !load_in_s;
  assign pop_s      = !fifo_empty_s && (!pf_valid_r || load_pf_s);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (M_Data),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (DMA_Write_Start) begin
          state_nx_s = (Write_Len == '0) ? DONE : RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (ack_s && ((out_cnt_r + CNT_ONE) == len_r)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (Done_Ack) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Control, counters, prefetch flag and the registered memory-write stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= '0;
      in_cnt_r    <= '0;
      out_cnt_r   <= '0;
      next_addr_r <= '0;
      mem_addr_r  <= '0;
      mem_data_r  <= '0;
      mem_wr_r    <= 1'b0;
      pf_valid_r  <= 1'b0;
      done_irq_r  <= 1'b0;
      busy_r      <= 1'b0;
      err_start_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      done_irq_r <= (state_nx_s == DONE);
      busy_r     <= (state_nx_s != IDLE);
      if (DMA_Write_Start && (state_r != IDLE)) err_start_r <= 1'b1;

      if (start_ok_s) begin
        len_r       <= Write_Len;
        in_cnt_r    <= '0;
        out_cnt_r   <= '0;
        next_addr_r <= Write_Base;
      end else begin
        if (accept_s) in_cnt_r <= in_cnt_r + CNT_ONE;
        if (ack_s) out_cnt_r <= out_cnt_r + CNT_ONE;
        if (load_s) next_addr_r <= next_addr_r + ADDR_ONE;
      end

      if (pop_s) begin
        pf_valid_r <= 1'b1;
      end else if (load_pf_s) begin
        pf_valid_r <= 1'b0;
      end

      if (load_s) begin
        mem_wr_r   <= 1'b1;
        mem_addr_r <= next_addr_r;
        mem_data_r <= load_pf_s ? fifo_dout_s : M_Data;
      end else if (ack_s) begin
        mem_wr_r <= 1'b0;
      end
    end
  end

  assign M_Ready   = m_ready_s;
  assign Mem_Addr  = mem_addr_r;
  assign Mem_Data  = mem_data_r;
  assign Mem_Wr    = mem_wr_r;
  assign Done_Irq  = done_irq_r;
  assign Busy      = busy_r;
  assign Err_Start = err_start_r;

endmodule

// File: tb/tb_dma_stream_writer.sv
// Bench for dma_stream_writer: random stream/ack timing scored against a queue of expected
// (base + i, beat i) writes derived directly from the transfer parameters.
module tb_dma_stream_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         DMA_Write_Start;
  logic [31:0]  Write_Base;
  logic [23:0]  Write_Len;
  logic [127:0] M_Data;
  logic         M_Valid;
  logic         M_Ready;
  logic [31:0]  Mem_Addr;
  logic [127:0] Mem_Data;
  logic         Mem_Wr;
  logic         Mem_Ack;
  logic         Done_Irq;
  logic         Done_Ack;
  logic         Busy;
  logic         Err_Start;

  int errors = 0;
  int checks = 0;

  logic [127:0] beats[$];
  logic [31:0]  cur_base;
  int           cur_len;
  int           acc_cnt, wr_cnt, extra_ready, first_acc, first_wr, last_ack, done_cyc;

  always #5 clk = ~clk;

  dma_stream_writer dut (
    .clk             (clk),
    .rst             (rst),
    .DMA_Write_Start (DMA_Write_Start),
    .Write_Base      (Write_Base),
    .Write_Len       (Write_Len),
    .M_Data          (M_Data),
    .M_Valid         (M_Valid),
    .M_Ready         (M_Ready),
    .Mem_Addr        (Mem_Addr),
    .Mem_Data        (Mem_Data),
    .Mem_Wr          (Mem_Wr),
    .Mem_Ack         (Mem_Ack),
    .Done_Irq        (Done_Irq),
    .Done_Ack        (Done_Ack),
    .Busy            (Busy),
    .Err_Start       (Err_Start)
  );

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_flags"}, int'({M_Ready, Mem_Wr, Done_Irq, Busy, Err_Start}), 0);
    check_vec({tag, "_addr_data"}, {Mem_Addr, Mem_Data}, 160'h0);
  endtask

  // Called at a falling edge: pulses start for one cycle with fresh random beat data.
  task automatic start(input logic [31:0] base, input int len);
    beats.delete();
    for (int i = 0; i < len + 4; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
    cur_base        = base;
    cur_len         = len;
    Write_Base      = base;
    Write_Len       = 24'(len);
    DMA_Write_Start = 1'b1;
    @(negedge clk);
    DMA_Write_Start = 1'b0;
  endtask

  // One cycle per iteration: drive at the falling edge, sample 1 time unit later.
  task automatic run(input int valid_pct, input int ack_pct, input int ack_hold,
                     input int inject_at, input int abort_after);
    logic [31:0] exp_addr;
    acc_cnt = 0; wr_cnt = 0; extra_ready = 0;
    first_acc = -1; first_wr = -1; last_ack = -1; done_cyc = -1;
    for (int c = 0; c < 600; c++) begin
      M_Valid         = (int'($urandom_range(99)) < valid_pct);
      M_Data          = beats[acc_cnt];
      Mem_Ack         = (c >= ack_hold) && (int'($urandom_range(99)) < ack_pct);
      DMA_Write_Start = (c == inject_at);
      #1;
      if (Done_Irq) begin
        done_cyc = c;
        break;
      end
      if (M_Ready && acc_cnt >= cur_len) extra_ready++;
      if (M_Valid && M_Ready) begin
        if (first_acc < 0) first_acc = c;
        acc_cnt++;
      end
      if (Mem_Wr && first_wr < 0) first_wr = c;
      if (Mem_Wr && Mem_Ack) begin
        if (wr_cnt < cur_len) begin
          exp_addr = cur_base + 32'(wr_cnt);
          check_vec("write", {Mem_Addr, Mem_Data}, {exp_addr, beats[wr_cnt]});
        end else begin
          check_int("write_beyond_len", wr_cnt, cur_len - 1);
        end
        wr_cnt++;
        last_ack = c;
      end
      if (c == ack_hold - 1) begin
        check_int("stall_accepted", acc_cnt, (cur_len < 16) ? cur_len : 16);
        check_int("stall_ready", int'(M_Ready), 0);
      end
      if (abort_after >= 0 && acc_cnt == abort_after) break;
      @(negedge clk);
    end
    DMA_Write_Start = 1'b0;
  endtask

  task automatic end_checks();
    check_int("done_seen", int'(done_cyc >= 0), 1);
    check_int("accepted", acc_cnt, cur_len);
    check_int("writes", wr_cnt, cur_len);
    check_int("ready_after_len", extra_ready, 0);
    check_int("done_timing", done_cyc, last_ack + 1);
    if (cur_len > 0) check_int("first_latency", first_wr, first_acc + 1);
    check_int("busy_in_done", int'(Busy), 1);
  endtask

  task automatic ack_done();
    Done_Ack = 1'b1;
    @(negedge clk);
    Done_Ack = 1'b0;
    #1;
    check_int("irq_cleared", int'(Done_Irq), 0);
    check_int("busy_cleared", int'(Busy), 0);
  endtask

  initial begin
    rst = 1'b1; DMA_Write_Start = 1'b0; Write_Base = 32'h0; Write_Len = 24'h0;
    M_Data = 128'h0; M_Valid = 1'b0; Mem_Ack = 1'b0; Done_Ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic transfer, stream and memory always ready
    start(32'h0000_0100, 4);
    run(100, 100, 0, -1, -1);
    end_checks();
    ack_done();

    // Memory stalled: buffer fills to its depth, then everything drains in order
    start(32'h0000_2000, 40);
    run(100, 70, 30, -1, -1);
    end_checks();
    ack_done();

    // Zero-length transfer
    start(32'h0000_3000, 0);
    run(100, 100, 0, -1, -1);
    end_checks();
    ack_done();
    check_int("no_err_yet", int'(Err_Start), 0);

    // Address wrap-around
    start(32'hFFFF_FFFE, 4);
    run(80, 80, 0, -1, -1);
    end_checks();
    ack_done();

    // Random gaps on both sides, random base
    start($urandom, 20);
    run(60, 60, 0, -1, -1);
    end_checks();
    ack_done();

    // Start pulse while running is ignored but flagged
    start(32'h0000_4000, 8);
    run(100, 50, 0, 3, -1);
    end_checks();
    check_int("err_start", int'(Err_Start), 1);
    ack_done();
    check_int("err_sticky", int'(Err_Start), 1);

    // Reset mid-transfer, then a clean short transfer
    start(32'h0000_5000, 10);
    run(100, 50, 0, -1, 5);
    rst = 1'b1;
    M_Valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(32'h0000_6000, 3);
    run(70, 70, 0, -1, -1);
    end_checks();
    ack_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
